// File: rtl/monopix2_cmd_pkg.sv
// Shared types and constants for the monopix2 command scheduler.
package monopix2_cmd_pkg;

    typedef logic [15:0] cmd_frame_t;

    localparam cmd_frame_t SYNC_WORD = 16'h817E;

    typedef enum logic [1:0] {
        SRC_TRIG,
        SRC_SYNC_FORCED,
        SRC_FIFO,
        SRC_SYNC_IDLE
    } cmd_src_t;

    function automatic logic is_sync_src(input cmd_src_t src);
        return (src == SRC_SYNC_FORCED) || (src == SRC_SYNC_IDLE);
    endfunction

endpackage

// File: rtl/monopix2_cmd_fifo.sv
// Register-write frame FIFO with registered full/empty flags.
// A push into an empty FIFO is stored, never bypassed to the output in the same cycle.
module monopix2_cmd_fifo
    import monopix2_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
)(
    input  logic        LVDS_CMD_CLK,
    input  logic        RESETB_EXT,
    input  logic        push,
    input  logic [15:0] push_data,
    input  logic        pop,
    output logic [15:0] head,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    cmd_frame_t     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [AW:0]    count_nxt;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    // NOTE: storage has no reset; resetting the pointers is what empties the FIFO.
    always_ff @(posedge LVDS_CMD_CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge LVDS_CMD_CLK or posedge RESETB_EXT) begin
        if (RESETB_EXT) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_L);
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/monopix2_cmd_scheduler.sv
// Command-frame arbiter and MSB-first serializer for LVDS_CMD.
// Optional external injection pulse is built only when CMD_PULSE_EN is defined.
module monopix2_cmd_scheduler
    import monopix2_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
`ifdef CMD_PULSE_EN
    parameter int PULSE_WIDTH   = 4,
`endif
    parameter int SYNC_INTERVAL = 32
)(
    input  logic        LVDS_CMD_CLK,
    input  logic        RESETB_EXT,
    input  logic        cmd_en,
    input  logic        trig_req,
    input  logic [15:0] trig_data,
    output logic        trig_ack,
    input  logic        reg_wr_valid,
    input  logic [15:0] reg_wr_data,
    output logic        reg_wr_ready,
`ifdef CMD_PULSE_EN
    input  logic        pulse_req,
    output logic        LVDS_PULSE_EXT,
`endif
    output logic        LVDS_CMD,
    output logic        busy,
    output logic [7:0]  sync_cnt_o
);

    localparam logic [7:0] FORCE_AT = 8'(SYNC_INTERVAL - 1);

    cmd_frame_t shift_reg;
    cmd_frame_t next_frame;
    cmd_frame_t fifo_head;
    logic [3:0] bit_cnt;
    logic [7:0] sync_cnt;
    logic       cur_sync;
    logic       boundary;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;
    cmd_src_t   src;

    assign boundary     = (bit_cnt == 4'd15);
    assign reg_wr_ready = !fifo_full;
    assign fifo_push    = reg_wr_valid && reg_wr_ready;
    assign fifo_pop     = boundary && (src == SRC_FIFO);
    assign trig_ack     = boundary && (src == SRC_TRIG);
    assign LVDS_CMD     = shift_reg[15];
    assign busy         = !fifo_empty || !cur_sync;
    assign sync_cnt_o   = sync_cnt;

    monopix2_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .LVDS_CMD_CLK (LVDS_CMD_CLK),
        .RESETB_EXT   (RESETB_EXT),
        .push         (fifo_push),
        .push_data    (reg_wr_data),
        .pop          (fifo_pop),
        .head         (fifo_head),
        .full         (fifo_full),
        .empty        (fifo_empty)
    );

    // NOTE: defaults first so every path assigns src and next_frame; no latch can form.
    always_comb begin
        src        = SRC_SYNC_IDLE;
        next_frame = SYNC_WORD;
        if (trig_req && cmd_en) begin
            src        = SRC_TRIG;
            next_frame = trig_data;
        end else if (sync_cnt >= FORCE_AT) begin
            src = SRC_SYNC_FORCED;
        end else if (!fifo_empty && cmd_en) begin
            src        = SRC_FIFO;
            next_frame = fifo_head;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge LVDS_CMD_CLK or posedge RESETB_EXT) begin
        if (RESETB_EXT) begin
            shift_reg <= SYNC_WORD;
            bit_cnt   <= '0;
            sync_cnt  <= '0;
            cur_sync  <= 1'b1;
        end else begin
            bit_cnt <= bit_cnt + 4'd1;
            if (boundary) begin
                shift_reg <= next_frame;
                cur_sync  <= is_sync_src(src);
                if (is_sync_src(src)) begin
                    sync_cnt <= '0;
                end else if (sync_cnt != 8'hFF) begin
                    sync_cnt <= sync_cnt + 8'd1;
                end
            end else begin
                shift_reg <= {shift_reg[14:0], 1'b0};
            end
        end
    end

`ifdef CMD_PULSE_EN
    logic       pulse_pend;
    logic       pulse_on;
    logic [7:0] pulse_cnt;
    logic       pulse_fire;

    // Wait for a trigger load if one is requested, otherwise fire at the next boundary.
    assign pulse_fire     = boundary && pulse_pend && !pulse_on &&
                            ((src == SRC_TRIG) || !trig_req);
    assign LVDS_PULSE_EXT = pulse_on;

    always_ff @(posedge LVDS_CMD_CLK or posedge RESETB_EXT) begin
        if (RESETB_EXT) begin
            pulse_pend <= 1'b0;
            pulse_on   <= 1'b0;
            pulse_cnt  <= '0;
        end else begin
            if (pulse_fire) pulse_pend <= 1'b0;
            if (pulse_req)  pulse_pend <= 1'b1;
            if (pulse_fire) begin
                pulse_on  <= 1'b1;
                pulse_cnt <= 8'(PULSE_WIDTH - 1);
            end else if (pulse_on) begin
                if (pulse_cnt == '0) pulse_on  <= 1'b0;
                else                 pulse_cnt <= pulse_cnt - 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_monopix2_cmd_scheduler.sv
// Self-checking bench: queue-based frame model compared every cycle, plus directed literal checks.
module tb_monopix2_cmd_scheduler;
    import monopix2_cmd_pkg::*;

    localparam int DEPTH = 8;
    localparam int SINT  = 32;

    logic        LVDS_CMD_CLK = 1'b0;
    logic        RESETB_EXT   = 1'b1;
    logic        cmd_en       = 1'b0;
    logic        trig_req     = 1'b0;
    logic [15:0] trig_data    = '0;
    logic        reg_wr_valid = 1'b0;
    logic [15:0] reg_wr_data  = '0;
    logic        trig_ack;
    logic        reg_wr_ready;
    logic        LVDS_CMD;
    logic        busy;
    logic [7:0]  sync_cnt_o;
`ifdef CMD_PULSE_EN
    logic        pulse_req = 1'b0;
    logic        LVDS_PULSE_EXT;
`endif

    always #5 LVDS_CMD_CLK = ~LVDS_CMD_CLK;

    monopix2_cmd_scheduler dut (
        .LVDS_CMD_CLK   (LVDS_CMD_CLK),
        .RESETB_EXT     (RESETB_EXT),
        .cmd_en         (cmd_en),
        .trig_req       (trig_req),
        .trig_data      (trig_data),
        .trig_ack       (trig_ack),
        .reg_wr_valid   (reg_wr_valid),
        .reg_wr_data    (reg_wr_data),
        .reg_wr_ready   (reg_wr_ready),
`ifdef CMD_PULSE_EN
        .pulse_req      (pulse_req),
        .LVDS_PULSE_EXT (LVDS_PULSE_EXT),
`endif
        .LVDS_CMD       (LVDS_CMD),
        .busy           (busy),
        .sync_cnt_o     (sync_cnt_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Frame-level model: the wire carries frames back to back, 16 cycles each, from reset release.
    int          m_cyc;
    logic [15:0] m_frame;
    logic [15:0] m_q[$];
    int          m_since;
    bit          m_cur_sync;
    bit          m_acc;

    always @(posedge LVDS_CMD_CLK or posedge RESETB_EXT) begin
        if (RESETB_EXT) begin
            m_cyc      = 0;
            m_frame    = SYNC_WORD;
            m_q.delete();
            m_since    = 0;
            m_cur_sync = 1;
        end else begin
            m_acc = reg_wr_valid && (m_q.size() < DEPTH);
            if (m_cyc % 16 == 15) begin
                if (trig_req && cmd_en) begin
                    m_frame = trig_data;  m_cur_sync = 0;
                end else if (m_since >= SINT - 1) begin
                    m_frame = SYNC_WORD;  m_cur_sync = 1;
                end else if (m_q.size() > 0 && cmd_en) begin
                    m_frame = m_q.pop_front();  m_cur_sync = 0;
                end else begin
                    m_frame = SYNC_WORD;  m_cur_sync = 1;
                end
                if (m_cur_sync)         m_since = 0;
                else if (m_since < 255) m_since++;
            end
            if (m_acc) m_q.push_back(reg_wr_data);
            m_cyc++;
        end
    end

    logic [15:0] rx_sh = '0;
    logic [15:0] rx_log[$];
    bit          saw_ready_low = 0;

    always @(negedge LVDS_CMD_CLK) begin
        if (chk_en && !RESETB_EXT) begin
            check("cmd_bit",  LVDS_CMD, m_frame[15 - (m_cyc % 16)]);
            check("trig_ack", trig_ack, (m_cyc % 16 == 15) && trig_req && cmd_en);
            check("ready",    reg_wr_ready, m_q.size() < DEPTH);
            check("busy",     busy, (m_q.size() != 0) || !m_cur_sync);
            check("sync_cnt", sync_cnt_o, m_since);
            if (!reg_wr_ready) saw_ready_low = 1;
            rx_sh = {rx_sh[14:0], LVDS_CMD};
            if (m_cyc % 16 == 15) rx_log.push_back(rx_sh);
        end
    end

    task automatic tick();
        @(posedge LVDS_CMD_CLK);
        #2;
    endtask

    task automatic wait_pos(input int p);
        bit hit = 0;
        for (int i = 0; i < 32 && !hit; i++) begin
            if (m_cyc % 16 == p) hit = 1;
            else tick();
        end
        check("wait_pos_timeout", hit, 1);
    endtask

    task automatic push_one(input logic [15:0] d);
        bit done = 0;
        reg_wr_data  = d;
        reg_wr_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            done = reg_wr_ready;
            tick();
        end
        reg_wr_valid = 1'b0;
        check("push_timeout", done, 1);
    endtask

    function automatic logic [15:0] rx_at(input int idx);
        return (idx < rx_log.size()) ? rx_log[idx] : 16'hxxxx;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int t0;
        int lat;
        bit ack_seen;
        int ndata;
        int first_run;
        int second_run;
        bit in_first;

        cmd_en = 1'b1;
        repeat (3) @(posedge LVDS_CMD_CLK);
        #2;
        check("rst_cmd",      LVDS_CMD, 1);
        check("rst_busy",     busy, 0);
        check("rst_trig_ack", trig_ack, 0);
        check("rst_ready",    reg_wr_ready, 1);
        check("rst_sync_cnt", sync_cnt_o, 0);
        RESETB_EXT = 1'b0;
        chk_en     = 1;

        // Idle stream: only SYNC frames.
        base = rx_log.size();
        repeat (64) tick();
        for (int i = 0; i < 4; i++) check("t1_sync_frame", rx_at(base + i), 16'h817E);
        check("t1_busy", busy, 0);

        // Single register write goes out in the next frame.
        wait_pos(4);
        base = rx_log.size();
        push_one(16'hA5A5);
        repeat (48) tick();
        check("t2_cur",   rx_at(base),     16'h817E);
        check("t2_data",  rx_at(base + 1), 16'hA5A5);
        check("t2_after", rx_at(base + 2), 16'h817E);

        // Trigger beats a queued write in the same frame.
        wait_pos(2);
        base = rx_log.size();
        push_one(16'h1111);
        trig_data = 16'hF00F;
        trig_req  = 1'b1;
        t0        = m_cyc;
        lat       = -1;
        ack_seen  = 0;
        for (int i = 0; i < 40 && !ack_seen; i++) begin
            @(negedge LVDS_CMD_CLK);
            if (trig_ack) begin ack_seen = 1; lat = m_cyc - t0; end
        end
        check("t3_ack_seen", ack_seen, 1);
        check("t3_ack_latency", lat, 12);
        tick();
        trig_req = 1'b0;
        @(negedge LVDS_CMD_CLK);
        check("t3_ack_one_cycle", trig_ack, 0);
        repeat (40) tick();
        check("t3_trig_frame", rx_at(base + 1), 16'hF00F);
        check("t3_fifo_frame", rx_at(base + 2), 16'h1111);

        // cmd_en low holds the FIFO; frames stay SYNC until it returns.
        wait_pos(2);
        base = rx_log.size();
        push_one(16'h2222);
        cmd_en = 1'b0;
        repeat (32) tick();
        check("t_en_busy", busy, 1);
        cmd_en = 1'b1;
        repeat (32) tick();
        check("t_en_sync0", rx_at(base),     16'h817E);
        check("t_en_sync1", rx_at(base + 1), 16'h817E);
        check("t_en_sync2", rx_at(base + 2), 16'h817E);
        check("t_en_data",  rx_at(base + 3), 16'h2222);

        // Writer throttled on ready; forced SYNC after 31 data frames.
        base = rx_log.size();
        saw_ready_low = 0;
        for (int i = 0; i < 40; i++) push_one(16'h1000 + 16'(i));
        repeat (16 * 12) tick();
        check("t4_ready_dropped", saw_ready_low, 1);
        ndata = 0; first_run = 0; second_run = 0; in_first = 1;
        for (int i = base; i < rx_log.size(); i++) begin
            if (rx_log[i] != SYNC_WORD) begin
                check("t4_order", rx_log[i], 16'h1000 + 16'(ndata));
                ndata++;
                if (in_first) first_run++;
                else          second_run++;
            end else if (ndata > 0) begin
                in_first = 0;
            end
        end
        check("t4_count",      ndata, 40);
        check("t4_first_run",  first_run, 31);
        check("t4_second_run", second_run, 9);

        // Reset in the middle of a FIFO frame.
        push_one(16'h0000);
        push_one(16'h0000);
        push_one(16'h0000);
        for (int i = 0; i < 64 && !(m_cyc % 16 == 7 && !m_cur_sync); i++) tick();
        check("t5_mid_frame_bit", LVDS_CMD, 0);
        #1 RESETB_EXT = 1'b1;
        #1;
        check("t5_cmd_now",   LVDS_CMD, 1);
        check("t5_busy_now",  busy, 0);
        check("t5_ready_now", reg_wr_ready, 1);
        tick();
        RESETB_EXT = 1'b0;
        base = rx_log.size();
        repeat (48) tick();
        for (int i = 0; i < 3; i++) check("t5_sync_after", rx_at(base + i), 16'h817E);
        check("t5_busy_after", busy, 0);

`ifdef CMD_PULSE_EN
        // Pulse requested at bit 3: high for bits 0..3 of the next frame.
        wait_pos(3);
        pulse_req = 1'b1;
        tick();
        pulse_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge LVDS_CMD_CLK);
            check("t6_pulse", LVDS_PULSE_EXT, (i >= 12) && (i <= 15));
        end
`endif

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
